// File: rtl/mem_bus_arbiter.sv
// ----------------------------------------------------------------------------
// mem_bus_arbiter
//   Shares one tagged memory bus between the icache and dcache ports.
//   Each cycle one cache request is granted onto the bus. dcache normally
//   wins. icache wins once it has been refused STARVE_LIMIT consecutive
//   cycles. The memory's acceptance tag goes back to the granted side in the
//   same cycle. A tag table records which cache owns each outstanding load.
//   Returned data and tag are routed only to that owner.
//
// Ports
//   clock, reset         system clock, asynchronous active-high reset
//   Imem_*               icache request (LOAD only, STORE acts as NONE)
//   Imem2proc_*          icache acceptance tag / returned data + tag
//   Dmem_*               dcache request (LOAD / STORE) with store data
//   Dmem2proc_*          dcache acceptance tag / returned data + tag
//   proc2mem_*           request driven onto the memory bus
//   mem2proc_*           memory acceptance tag and returned data + tag
//   outstanding_cnt      number of valid tag-table entries (registered)
//   drop_err             returned tag had no owner (single-cycle pulse)
// ----------------------------------------------------------------------------
module mem_bus_arbiter #(
   parameter int XLEN         = 32,
   parameter int STARVE_LIMIT = 4,
   parameter int NUM_TAGS     = 16
) (
   input  logic            clock,
   input  logic            reset,
   input  logic [1:0]      Imem_command,
   input  logic [XLEN-1:0] Imem_addr,
   output logic [3:0]      Imem2proc_response,
   output logic [63:0]     Imem2proc_data,
   output logic [3:0]      Imem2proc_tag,
   input  logic [1:0]      Dmem_command,
   input  logic [XLEN-1:0] Dmem_addr,
   input  logic [63:0]     Dmem_data,
   output logic [3:0]      Dmem2proc_response,
   output logic [63:0]     Dmem2proc_data,
   output logic [3:0]      Dmem2proc_tag,
   output logic [1:0]      proc2mem_command,
   output logic [XLEN-1:0] proc2mem_addr,
   output logic [63:0]     proc2mem_data,
   input  logic [3:0]      mem2proc_response,
   input  logic [63:0]     mem2proc_data,
   input  logic [3:0]      mem2proc_tag,
   output logic [4:0]      outstanding_cnt,
   output logic            drop_err
);

   localparam logic [1:0] BUS_NONE   = 2'd0;
   localparam logic [1:0] BUS_LOAD   = 2'd1;
   localparam logic [1:0] BUS_STORE  = 2'd2;
   localparam logic [3:0] STARVE_LIM = 4'(STARVE_LIMIT);

   // Table state: valid bits are control (reset), owner bits are data (not reset).
   // Owner encoding: 1 = dcache, 0 = icache.
   logic [NUM_TAGS-1:0] tag_vld;
   logic [NUM_TAGS-1:0] tag_vld_nxt;
   logic [NUM_TAGS-1:0] tag_own;
   logic [3:0]          starve_cnt;
   logic [3:0]          starve_nxt;

   logic i_req, d_req, grant_i, grant_d;
   logic ret_hit, ret_own, alloc;

   function automatic logic [3:0] sat_inc(input logic [3:0] v);
      return (v == 4'hF) ? v : v + 4'd1;
   endfunction

   function automatic logic [4:0] popcount(input logic [NUM_TAGS-1:0] v);
      logic [4:0] n;
      n = '0;
      for (int i = 0; i < NUM_TAGS; i++) n = n + 5'(v[i]);
      return n;
   endfunction

   // Grant selection: dcache has priority unless icache has starved.
   always_comb begin
      i_req   = (Imem_command == BUS_LOAD);
      d_req   = (Dmem_command == BUS_LOAD) || (Dmem_command == BUS_STORE);
      grant_i = i_req && (!d_req || (starve_cnt >= STARVE_LIM));
      grant_d = d_req && !grant_i;
   end

   // Return lookup uses the registered table, so a tag returned and
   // reallocated in the same cycle still routes to its previous owner.
   always_comb begin
      ret_hit = (mem2proc_tag != 4'd0) && tag_vld[mem2proc_tag];
      ret_own = tag_own[mem2proc_tag];
   end

   // All outputs are forced to zero while reset is held.
   always_comb begin
      proc2mem_command   = BUS_NONE;
      proc2mem_addr      = '0;
      proc2mem_data      = '0;
      Imem2proc_response = 4'd0;
      Dmem2proc_response = 4'd0;
      Imem2proc_tag      = 4'd0;
      Imem2proc_data     = '0;
      Dmem2proc_tag      = 4'd0;
      Dmem2proc_data     = '0;
      drop_err           = 1'b0;
      if (!reset) begin
         if (grant_i) begin
            proc2mem_command   = BUS_LOAD;
            proc2mem_addr      = Imem_addr;
            Imem2proc_response = mem2proc_response;
         end else if (grant_d) begin
            proc2mem_command   = Dmem_command;
            proc2mem_addr      = Dmem_addr;
            proc2mem_data      = Dmem_data;
            Dmem2proc_response = mem2proc_response;
         end
         if (ret_hit) begin
            if (ret_own) begin
               Dmem2proc_tag  = mem2proc_tag;
               Dmem2proc_data = mem2proc_data;
            end else begin
               Imem2proc_tag  = mem2proc_tag;
               Imem2proc_data = mem2proc_data;
            end
         end
         drop_err = (mem2proc_tag != 4'd0) && !tag_vld[mem2proc_tag];
      end
   end

   // Table update: clear on return first, so an allocation to the same tag wins.
   always_comb begin
      alloc       = (proc2mem_command == BUS_LOAD) && (mem2proc_response != 4'd0);
      tag_vld_nxt = tag_vld;
      if (ret_hit) tag_vld_nxt[mem2proc_tag] = 1'b0;
      if (alloc)   tag_vld_nxt[mem2proc_response] = 1'b1;
      starve_nxt = ((Imem_command == BUS_LOAD) && (Imem2proc_response == 4'd0)) ?
                   sat_inc(starve_cnt) : 4'd0;
   end

   // ---- stage boundary: table and counters registered ----
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         tag_vld         <= '0;
         outstanding_cnt <= 5'd0;
         starve_cnt      <= 4'd0;
      end else begin
         tag_vld         <= tag_vld_nxt;
         outstanding_cnt <= popcount(tag_vld_nxt);
         starve_cnt      <= starve_nxt;
      end
   end

   always_ff @(posedge clock) begin
      if (alloc) tag_own[mem2proc_response] <= grant_d;
   end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
module tb_mem_bus_arbiter;

   localparam int XLEN = 32;
   localparam int LIM  = 4;

   logic            clock, reset;
   logic [1:0]      Imem_command, Dmem_command, proc2mem_command;
   logic [XLEN-1:0] Imem_addr, Dmem_addr, proc2mem_addr;
   logic [63:0]     Dmem_data, proc2mem_data, mem2proc_data;
   logic [63:0]     Imem2proc_data, Dmem2proc_data;
   logic [3:0]      Imem2proc_response, Imem2proc_tag;
   logic [3:0]      Dmem2proc_response, Dmem2proc_tag;
   logic [3:0]      mem2proc_response, mem2proc_tag;
   logic [4:0]      outstanding_cnt;
   logic            drop_err;

   mem_bus_arbiter #(.XLEN(XLEN), .STARVE_LIMIT(LIM), .NUM_TAGS(16)) dut (
      .clock(clock), .reset(reset),
      .Imem_command(Imem_command), .Imem_addr(Imem_addr),
      .Imem2proc_response(Imem2proc_response), .Imem2proc_data(Imem2proc_data),
      .Imem2proc_tag(Imem2proc_tag),
      .Dmem_command(Dmem_command), .Dmem_addr(Dmem_addr), .Dmem_data(Dmem_data),
      .Dmem2proc_response(Dmem2proc_response), .Dmem2proc_data(Dmem2proc_data),
      .Dmem2proc_tag(Dmem2proc_tag),
      .proc2mem_command(proc2mem_command), .proc2mem_addr(proc2mem_addr),
      .proc2mem_data(proc2mem_data),
      .mem2proc_response(mem2proc_response), .mem2proc_data(mem2proc_data),
      .mem2proc_tag(mem2proc_tag),
      .outstanding_cnt(outstanding_cnt), .drop_err(drop_err)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   typedef struct packed {
      logic [1:0]  cmd;
      logic [31:0] addr;
      logic [63:0] data;
      logic [4:0]  cnt;
      logic        drop;
      logic        hit;
      logic [63:0] idata;
      logic [63:0] ddata;
   } cyc_t;

   typedef struct packed {
      logic       side;   // 0 icache, 1 dcache
      logic [3:0] tag;
   } rsp_t;

   typedef struct packed {
      logic        side;
      logic [3:0]  tag;
      logic [63:0] data;
   } ret_t;

   cyc_t cycq[$];
   rsp_t rspq[$];
   ret_t retq[$];

   int checks = 0;
   int errors = 0;
   logic mon_en = 1'b0;

   // Reference model: owner of each tag (0 none, 1 icache, 2 dcache) and starve count.
   int own[16];
   int starve;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s act=%0h exp=%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < 16; i++) own[i] = 0;
      starve = 0;
   endtask

   function automatic int model_cnt();
      int n = 0;
      for (int i = 0; i < 16; i++) if (own[i] != 0) n++;
      return n;
   endfunction

   task automatic set_idle();
      Imem_command = 2'd0; Imem_addr = '0;
      Dmem_command = 2'd0; Dmem_addr = '0; Dmem_data = '0;
      mem2proc_response = 4'd0; mem2proc_tag = 4'd0; mem2proc_data = '0;
   endtask

   // Drives one cycle, queues the expected outputs, and advances the model.
   task automatic cycle(input logic [1:0] ic, input logic [31:0] ia,
                        input logic [1:0] dc, input logic [31:0] da, input logic [63:0] dd,
                        input logic [3:0] mr, input logic [3:0] mt, input logic [63:0] md);
      int   side;
      bit   ireq, dreq;
      cyc_t c;
      logic [3:0] ir, dr;
      @(posedge clock); #1;
      Imem_command = ic; Imem_addr = ia;
      Dmem_command = dc; Dmem_addr = da; Dmem_data = dd;
      mem2proc_response = mr; mem2proc_tag = mt; mem2proc_data = md;

      ireq = (ic == 2'd1);
      dreq = (dc == 2'd1) || (dc == 2'd2);
      side = 0;
      if (ireq && dreq) side = (starve >= LIM) ? 1 : 2;
      else if (ireq)    side = 1;
      else if (dreq)    side = 2;

      c.cmd   = (side == 1) ? 2'd1 : (side == 2) ? dc : 2'd0;
      c.addr  = (side == 1) ? ia : (side == 2) ? da : 32'd0;
      c.data  = (side == 2) ? dd : 64'd0;
      c.cnt   = 5'(model_cnt());
      c.hit   = (mt != 0) && (own[mt] != 0);
      c.drop  = (mt != 0) && (own[mt] == 0);
      c.idata = (c.hit && own[mt] == 1) ? md : 64'd0;
      c.ddata = (c.hit && own[mt] == 2) ? md : 64'd0;
      cycq.push_back(c);

      ir = (side == 1) ? mr : 4'd0;
      dr = (side == 2) ? mr : 4'd0;
      if (ir != 0) rspq.push_back('{side: 1'b0, tag: ir});
      if (dr != 0) rspq.push_back('{side: 1'b1, tag: dr});
      if (c.hit) retq.push_back('{side: (own[mt] == 2), tag: mt, data: md});

      if (c.hit) own[mt] = 0;
      if (c.cmd == 2'd1 && mr != 0) own[mr] = side;
      starve = (ic == 2'd1 && ir == 0) ? ((starve < 15) ? starve + 1 : 15) : 0;
   endtask

   // Monitor: compares whatever the DUT presents against the queued expectations.
   always @(negedge clock) begin
      if (mon_en) begin
         cyc_t c;
         rsp_t r;
         ret_t t;
         if (cycq.size() > 0) begin
            c = cycq.pop_front();
            chk("bus_cmd", 64'(proc2mem_command), 64'(c.cmd));
            chk("bus_addr", 64'(proc2mem_addr), 64'(c.addr));
            chk("bus_data", proc2mem_data, c.data);
            chk("outstanding_cnt", 64'(outstanding_cnt), 64'(c.cnt));
            chk("drop_err", 64'(drop_err), 64'(c.drop));
            if (c.hit) begin
               chk("i_ret_data", Imem2proc_data, c.idata);
               chk("d_ret_data", Dmem2proc_data, c.ddata);
            end
         end
         if (Imem2proc_response != 4'd0) begin
            if (rspq.size() == 0) chk("i_resp_unexpected", 64'(Imem2proc_response), 64'd0);
            else begin
               r = rspq.pop_front();
               chk("i_resp", 64'({1'b0, Imem2proc_response}), 64'({r.side, r.tag}));
            end
         end
         if (Dmem2proc_response != 4'd0) begin
            if (rspq.size() == 0) chk("d_resp_unexpected", 64'(Dmem2proc_response), 64'd0);
            else begin
               r = rspq.pop_front();
               chk("d_resp", 64'({1'b1, Dmem2proc_response}), 64'({r.side, r.tag}));
            end
         end
         if (Imem2proc_tag != 4'd0) begin
            if (retq.size() == 0) chk("i_ret_unexpected", 64'(Imem2proc_tag), 64'd0);
            else begin
               t = retq.pop_front();
               chk("i_ret_tag", 64'({1'b0, Imem2proc_tag}), 64'({t.side, t.tag}));
               chk("i_ret_payload", Imem2proc_data, t.data);
            end
         end
         if (Dmem2proc_tag != 4'd0) begin
            if (retq.size() == 0) chk("d_ret_unexpected", 64'(Dmem2proc_tag), 64'd0);
            else begin
               t = retq.pop_front();
               chk("d_ret_tag", 64'({1'b1, Dmem2proc_tag}), 64'({t.side, t.tag}));
               chk("d_ret_payload", Dmem2proc_data, t.data);
            end
         end
      end
   end

   task automatic chk_all_zero(input string tagname);
      chk({tagname, "_cmd"}, 64'(proc2mem_command), 64'd0);
      chk({tagname, "_addr"}, 64'(proc2mem_addr), 64'd0);
      chk({tagname, "_data"}, proc2mem_data, 64'd0);
      chk({tagname, "_iresp"}, 64'(Imem2proc_response), 64'd0);
      chk({tagname, "_dresp"}, 64'(Dmem2proc_response), 64'd0);
      chk({tagname, "_itag"}, 64'(Imem2proc_tag), 64'd0);
      chk({tagname, "_dtag"}, 64'(Dmem2proc_tag), 64'd0);
      chk({tagname, "_drop"}, 64'(drop_err), 64'd0);
      chk({tagname, "_cnt"}, 64'(outstanding_cnt), 64'd0);
   endtask

   initial begin
      int tags[$];
      logic [1:0]  ic, dc;
      logic [3:0]  mr, mt;
      model_reset();

      // Reset with active inputs: every output must stay zero.
      reset = 1'b1;
      Imem_command = 2'd1; Imem_addr = 32'h100;
      Dmem_command = 2'd2; Dmem_addr = 32'h400; Dmem_data = 64'h55;
      mem2proc_response = 4'd3; mem2proc_tag = 4'd3; mem2proc_data = 64'h1;
      #2;
      chk_all_zero("reset");
      #10;
      set_idle();
      reset  = 1'b0;
      mon_en = 1'b1;

      // 1) icache load, later returned to icache only
      cycle(2'd1, 32'h100, 2'd0, 0, 0, 4'd3, 4'd0, 0);
      #1 chk("t1_iresp", 64'(Imem2proc_response), 64'd3);
      cycle(2'd0, 0, 2'd0, 0, 0, 4'd0, 4'd0, 0);
      cycle(2'd0, 0, 2'd0, 0, 0, 4'd0, 4'd3, 64'hDEAD_BEEF_0000_0013);
      #1;
      chk("t1_itag", 64'(Imem2proc_tag), 64'd3);
      chk("t1_idata", Imem2proc_data, 64'hDEAD_BEEF_0000_0013);
      chk("t1_dtag", 64'(Dmem2proc_tag), 64'd0);

      // 2) simultaneous loads: dcache wins
      cycle(2'd1, 32'h200, 2'd1, 32'h300, 0, 4'd5, 4'd0, 0);
      #1;
      chk("t2_addr", 64'(proc2mem_addr), 64'h300);
      chk("t2_dresp", 64'(Dmem2proc_response), 64'd5);
      chk("t2_iresp", 64'(Imem2proc_response), 64'd0);
      cycle(2'd0, 0, 2'd0, 0, 0, 4'd0, 4'd5, 64'h1234_5678_9ABC_DEF0);
      #1 chk("t2_dtag", 64'(Dmem2proc_tag), 64'd5);

      // 5) return of an unowned tag
      cycle(2'd0, 0, 2'd0, 0, 0, 4'd0, 4'd9, 64'hFF);
      #1;
      chk("t5_drop", 64'(drop_err), 64'd1);
      chk("t5_itag", 64'(Imem2proc_tag), 64'd0);
      chk("t5_dtag", 64'(Dmem2proc_tag), 64'd0);
      cycle(2'd0, 0, 2'd0, 0, 0, 4'd0, 4'd0, 0);
      #1 chk("t5_drop_clear", 64'(drop_err), 64'd0);

      // 4) dcache store allocates nothing
      cycle(2'd0, 0, 2'd2, 32'h400, 64'h55, 4'd7, 4'd0, 0);
      #1;
      chk("t4_data", proc2mem_data, 64'h55);
      chk("t4_dresp", 64'(Dmem2proc_response), 64'd7);
      cycle(2'd0, 0, 2'd0, 0, 0, 4'd0, 4'd0, 0);
      #1 chk("t4_cnt", 64'(outstanding_cnt), 64'd0);

      // 6) two loads outstanding, then asynchronous reset mid-cycle
      cycle(2'd1, 32'h500, 2'd0, 0, 0, 4'd10, 4'd0, 0);
      cycle(2'd0, 0, 2'd1, 32'h600, 0, 4'd11, 4'd0, 0);
      cycle(2'd0, 0, 2'd0, 0, 0, 4'd0, 4'd0, 0);
      #1 chk("t6_cnt_before", 64'(outstanding_cnt), 64'd2);
      @(negedge clock); #1;
      mon_en = 1'b0;
      reset  = 1'b1;
      #1 chk("t6_cnt_reset", 64'(outstanding_cnt), 64'd0);
      Imem_command = 2'd1; Imem_addr = 32'h700; mem2proc_response = 4'd4; mem2proc_tag = 4'd10;
      #1 chk_all_zero("t6_in_reset");
      @(posedge clock); #1;
      chk("t6_cnt_hold", 64'(outstanding_cnt), 64'd0);
      set_idle();
      @(negedge clock); #1;
      reset = 1'b0;
      model_reset();
      mon_en = 1'b1;
      cycle(2'd0, 0, 2'd0, 0, 0, 4'd0, 4'd10, 64'hA);
      #1 chk("t6_drop10", 64'(drop_err), 64'd1);
      cycle(2'd0, 0, 2'd0, 0, 0, 4'd0, 4'd11, 64'hB);
      #1 chk("t6_drop11", 64'(drop_err), 64'd1);

      // 3) continuous contention: icache gets the bus on the fifth cycle
      for (int k = 1; k <= 6; k++) begin
         cycle(2'd1, 32'h1000 + 32'(k), 2'd1, 32'h2000 + 32'(k), 0, 4'(k), 4'd0, 0);
         #1 chk($sformatf("t3_addr_c%0d", k), 64'(proc2mem_addr),
                (k == 5) ? 64'h1000 + 64'(k) : 64'h2000 + 64'(k));
      end

      // Randomized traffic
      for (int n = 0; n < 400; n++) begin
         int p;
         tags.delete();
         for (int i = 1; i < 16; i++) if (own[i] != 0) tags.push_back(i);
         p  = $urandom_range(0, 9);
         ic = (p < 6) ? 2'd1 : (p < 8) ? 2'd0 : 2'd2;
         p  = $urandom_range(0, 9);
         dc = (p < 4) ? 2'd1 : (p < 6) ? 2'd2 : 2'd0;
         mr = ($urandom_range(0, 9) < 7) ? 4'($urandom_range(1, 15)) : 4'd0;
         p  = $urandom_range(0, 9);
         if (p < 4 && tags.size() > 0) mt = 4'(tags[$urandom_range(0, tags.size() - 1)]);
         else if (p < 5)               mt = 4'($urandom_range(1, 15));
         else                          mt = 4'd0;
         cycle(ic, $urandom, dc, $urandom, {$urandom, $urandom}, mr, mt, {$urandom, $urandom});
      end

      cycle(2'd0, 0, 2'd0, 0, 0, 4'd0, 4'd0, 0);
      @(negedge clock); #1;
      chk("cycq_drain", 64'(cycq.size()), 64'd0);
      chk("rspq_drain", 64'(rspq.size()), 64'd0);
      chk("retq_drain", 64'(retq.size()), 64'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
